// File: rtl/prefix_adder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prefix_adder_pkg                                                         |
// | Shared types and constants for the prefix-adder arbitration slice.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package prefix_adder_pkg;

  localparam int ADD_W    = 6;
  // Widest requester id the response record can carry (up to 256 requesters).
  localparam int ID_W_MAX = 8;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [ADD_W-1:0]    sum;
    logic                cout;
    logic [ID_W_MAX-1:0] id;
    logic                last;
  } add_rsp_t;

endpackage
`default_nettype wire

// File: rtl/prefix_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prefix_adder                                                             |
// | Kogge-Stone parallel-prefix adder: s = x + y + c_in, WIDTH+1 bits.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module prefix_adder #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  output logic [WIDTH:0]   s
);

  logic [WIDTH-1:0] w_prop;
  logic [WIDTH-1:0] w_gen;
  logic [WIDTH-1:0] w_grp_p;
  logic [WIDTH-1:0] w_nxt_g;
  logic [WIDTH-1:0] w_nxt_p;
  logic [WIDTH-1:0] w_carry;

  always_comb begin
    w_prop  = x ^ y;
    w_gen   = x & y;
    w_grp_p = w_prop;
    // Folding c_in into bit 0 makes every group generate a true carry-out.
    w_gen[0] = w_gen[0] | (w_prop[0] & c_in);
    w_nxt_g  = w_gen;
    w_nxt_p  = w_grp_p;
    for (int d = 1; d < WIDTH; d = d * 2) begin
      w_nxt_g = w_gen;
      w_nxt_p = w_grp_p;
      for (int i = d; i < WIDTH; i++) begin
        w_nxt_g[i] = w_gen[i] | (w_grp_p[i] & w_gen[i-d]);
        w_nxt_p[i] = w_grp_p[i] & w_grp_p[i-d];
      end
      w_gen   = w_nxt_g;
      w_grp_p = w_nxt_p;
    end
    w_carry = {w_gen[WIDTH-2:0], c_in};
    s       = {w_gen[WIDTH-1], w_prop ^ w_carry};
  end

endmodule
`default_nettype wire

// File: rtl/prefix_adder_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prefix_adder_arbiter_rr_pick                                             |
// | Combinational round-robin picker: first valid at or after rr_ptr.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module prefix_adder_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any
);

  logic [NUM_REQ-1:0] w_rot;
  logic [ID_W-1:0]    w_off;
  logic [ID_W:0]      w_idx;

  always_comb begin
    // Rotate so that position 0 is the requester rr_ptr points at.
    w_rot = NUM_REQ'({valid, valid} >> rr_ptr);
    w_off = '0;
    any   = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = ID_W'(i);
        any   = 1'b1;
      end
    end
    w_idx = {1'b0, rr_ptr} + {1'b0, w_off};
    if (w_idx >= (ID_W+1)'(NUM_REQ)) begin
      w_idx = w_idx - (ID_W+1)'(NUM_REQ);
    end
    grant_id = w_idx[ID_W-1:0];
    grant    = any ? (NUM_REQ'(1) << grant_id) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/prefix_adder_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prefix_adder_arbiter                                                     |
// | Round-robin sharing of one prefix_adder with multi-beat carry chaining.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module prefix_adder_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int ADD_W   = 6,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*ADD_W-1:0] req_x,
  input  logic [NUM_REQ*ADD_W-1:0] req_y,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ADD_W-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_last
);

  import prefix_adder_pkg::*;

  arb_state_t       r_state;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_owner;
  logic             r_carry;
  logic             r_rsp_valid;
  add_rsp_t         r_rsp;

  logic [NUM_REQ-1:0] w_pick_grant;
  logic [ID_W-1:0]    w_pick_id;
  logic               w_pick_any;
  logic               w_locked;
  logic               w_slot_free;
  logic               w_sel_valid;
  logic [ID_W-1:0]    w_sel_id;
  logic [ID_W-1:0]    w_next_ptr;
  logic [NUM_REQ-1:0] w_grant_vec;
  logic               w_accept;
  logic [ADD_W-1:0]   w_x;
  logic [ADD_W-1:0]   w_y;
  logic               w_cin;
  logic [ADD_W:0]     w_s;
  add_rsp_t           w_rsp_next;
  logic               w_unused_id;

  logic [ADD_W-1:0] w_x_arr [NUM_REQ];
  logic [ADD_W-1:0] w_y_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_x_arr[i] = req_x[i*ADD_W +: ADD_W];
    assign w_y_arr[i] = req_y[i*ADD_W +: ADD_W];
  end

  prefix_adder_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .valid    (req_valid),
    .rr_ptr   (r_rr_ptr),
    .grant    (w_pick_grant),
    .grant_id (w_pick_id),
    .any      (w_pick_any)
  );

  always_comb begin
    w_locked    = (r_state == ARB_LOCKED);
    w_slot_free = !r_rsp_valid || rsp_ready;
    // While locked the owner is the only candidate, valid or not.
    w_sel_id    = w_locked ? r_owner : w_pick_id;
    w_sel_valid = w_locked ? req_valid[r_owner] : w_pick_any;
    w_grant_vec = w_locked ? (NUM_REQ'(1) << r_owner) : w_pick_grant;
    w_accept    = rst_n && w_slot_free && w_sel_valid;
    req_ready   = w_accept ? w_grant_vec : '0;
    w_x         = w_x_arr[w_sel_id];
    w_y         = w_y_arr[w_sel_id];
    w_cin       = w_locked ? r_carry : req_cin[w_sel_id];
    w_next_ptr  = (w_sel_id == ID_W'(NUM_REQ - 1)) ? '0 : w_sel_id + 1'b1;
  end

  prefix_adder #(
    .WIDTH (ADD_W)
  ) u_prefix_adder (
    .x    (w_x),
    .y    (w_y),
    .c_in (w_cin),
    .s    (w_s)
  );

  always_comb begin
    w_rsp_next      = '0;
    w_rsp_next.sum  = w_s[ADD_W-1:0];
    w_rsp_next.cout = w_s[ADD_W];
    w_rsp_next.id   = ID_W_MAX'(w_sel_id);
    w_rsp_next.last = req_last[w_sel_id];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ARB_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_carry     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp       <= '0;
    end else begin
      if (w_accept) begin
        r_rsp       <= w_rsp_next;
        r_rsp_valid <= 1'b1;
        if (w_rsp_next.last) begin
          r_state  <= ARB_IDLE;
          r_rr_ptr <= w_next_ptr;
          r_carry  <= 1'b0;
        end else begin
          r_state  <= ARB_LOCKED;
          r_owner  <= w_sel_id;
          r_carry  <= w_s[ADD_W];
        end
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_sum     = r_rsp.sum;
  assign rsp_cout    = r_rsp.cout;
  assign rsp_id      = r_rsp.id[ID_W-1:0];
  assign rsp_last    = r_rsp.last;
  assign w_unused_id = ^r_rsp.id;

endmodule
`default_nettype wire
